// File: rtl/npc_sequencer_pkg.sv
// Shared constants, state encoding and target-select codes for the
// next-PC sequencer.
package npc_sequencer_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_HI  = 32'h0000_6FFC;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam logic [1:0] SEL_SEQ = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_J   = 2'd2;
  localparam logic [1:0] SEL_JR  = 2'd3;

  function automatic logic out_of_range(input logic [31:0] addr,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    return (addr < lo) || (addr > hi);
  endfunction

endpackage

// File: rtl/npc_target_calc.sv
// Combinational next-PC candidate mux: sequential, branch, j/jal, jr.
module npc_target_calc
  import npc_sequencer_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [31:0] id_pc4,
  input  logic [15:0] br_imm16,
  input  logic [25:0] j_idx,
  input  logic [29:0] jr_word,
  input  logic [1:0]  sel,
  output logic [31:0] target
);

  logic [31:0] br_off;

  // Word offset, sign-extended and scaled to bytes; the sum wraps mod 2^32.
  assign br_off = {{14{br_imm16[15]}}, br_imm16, 2'b00};

  always_comb begin
    target = pc4;
    case (sel)
      SEL_BR:  target = id_pc4 + br_off;
      SEL_J:   target = {id_pc4[31:28], j_idx, 2'b00};
      SEL_JR:  target = {jr_word, 2'b00};
      default: target = pc4;
    endcase
  end

endmodule

// File: rtl/npc_sequencer.sv
// Fetch PC register and next-PC FSM; parks a redirect that arrives during a
// stall and applies it when the stall releases.
module npc_sequencer
  import npc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] IMEM_LO  = DEF_IMEM_LO,
  parameter logic [31:0] IMEM_HI  = DEF_IMEM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] id_pc4,
  input  logic        br_req,
  input  logic        br_taken,
  input  logic [15:0] br_imm16,
  input  logic        j_req,
  input  logic [25:0] j_idx,
  input  logic        jr_req,
  input  logic [31:0] jr_tgt,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        pending,
  output logic        err_conflict,
  output logic        err_align,
  output logic        err_range
);

  state_t      state;
  logic [31:0] saved;
  logic        br_hit, redir, multi;
  logic [1:0]  sel;
  logic [31:0] target;
  logic        load_en;
  logic [31:0] load_val;

  assign pc4     = pc + 32'd4;
  assign pending = (state == PENDING);

  assign br_hit = br_req & br_taken;
  assign redir  = jr_req | j_req | br_hit;
  assign multi  = (jr_req & j_req) | (jr_req & br_hit) | (j_req & br_hit);

  always_comb begin
    sel = SEL_SEQ;
    if (jr_req)      sel = SEL_JR;
    else if (j_req)  sel = SEL_J;
    else if (br_hit) sel = SEL_BR;
  end

  npc_target_calc u_calc (
    .pc4      (pc4),
    .id_pc4   (id_pc4),
    .br_imm16 (br_imm16),
    .j_idx    (j_idx),
    .jr_word  (jr_tgt[31:2]),
    .sel      (sel),
    .target   (target)
  );

  // Only a released stall ever moves the PC; the source depends on state.
  always_comb begin
    load_en  = 1'b0;
    load_val = target;
    if (!stall) begin
      load_en  = 1'b1;
      load_val = (state == PENDING) ? saved : target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc           <= RESET_PC;
      state        <= IDLE;
      saved        <= '0;
      err_conflict <= 1'b0;
      err_align    <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      if (load_en) pc <= load_val;
      if (load_en && out_of_range(load_val, IMEM_LO, IMEM_HI)) err_range <= 1'b1;

      case (state)
        IDLE: begin
          if (stall && redir) begin
            saved <= target;
            state <= PENDING;
          end
          if (multi) err_conflict <= 1'b1;
          if (jr_req && (jr_tgt[1:0] != 2'b00)) err_align <= 1'b1;
        end
        PENDING: begin
          // A redirect here sits in a delay slot: flag it and drop it.
          if (redir) err_conflict <= 1'b1;
          if (!stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_sequencer.sv
// Directed-vector bench for npc_sequencer with hand-computed expectations.
module tb_npc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] id_pc4;
  logic        br_req, br_taken;
  logic [15:0] br_imm16;
  logic        j_req;
  logic [25:0] j_idx;
  logic        jr_req;
  logic [31:0] jr_tgt;
  logic [31:0] pc, pc4;
  logic        pending, err_conflict, err_align, err_range;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  npc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .id_pc4       (id_pc4),
    .br_req       (br_req),
    .br_taken     (br_taken),
    .br_imm16     (br_imm16),
    .j_req        (j_req),
    .j_idx        (j_idx),
    .jr_req       (jr_req),
    .jr_tgt       (jr_tgt),
    .pc           (pc),
    .pc4          (pc4),
    .pending      (pending),
    .err_conflict (err_conflict),
    .err_align    (err_align),
    .err_range    (err_range)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_pulses();
    br_req = 0; br_taken = 0; j_req = 0; jr_req = 0;
  endtask

  task automatic chk_flags(input string tag, input logic p, input logic c,
                           input logic a, input logic r);
    chk({tag, "_pending"},  {31'd0, pending},      {31'd0, p});
    chk({tag, "_conflict"}, {31'd0, err_conflict}, {31'd0, c});
    chk({tag, "_align"},    {31'd0, err_align},    {31'd0, a});
    chk({tag, "_range"},    {31'd0, err_range},    {31'd0, r});
  endtask

  initial begin
    reset = 0; stall = 0; id_pc4 = 0; br_imm16 = 0; j_idx = 0; jr_tgt = 0;
    clr_pulses();
    tick(); tick();
    reset = 1;
    chk("rst_pc", pc, 32'h3000);
    chk_flags("rst", 0, 0, 0, 0);

    // Free-running sequential fetch
    tick(); chk("seq1", pc, 32'h3004);
    tick(); chk("seq2", pc, 32'h3008);
    tick(); chk("seq3", pc, 32'h300C);
    chk("seq3_pc4", pc4, 32'h3010);

    // Taken branch backwards: 0x3004 + (-1 << 2)
    id_pc4 = 32'h3004; br_imm16 = 16'hFFFF; br_req = 1; br_taken = 1;
    tick(); clr_pulses();
    chk("br_back", pc, 32'h3000);

    // Taken branch forwards: 0x3004 + (4 << 2)
    br_imm16 = 16'h0004; br_req = 1; br_taken = 1;
    tick(); clr_pulses();
    chk("br_fwd", pc, 32'h3014);

    // Not-taken branch is just sequential
    br_req = 1; br_taken = 0;
    tick(); clr_pulses();
    chk("br_nt", pc, 32'h3018);

    // j: {0x0, 0x0000C10, 00} = 0x3040
    id_pc4 = 32'h3008; j_idx = 26'h0000C10; j_req = 1;
    tick(); clr_pulses();
    chk("j", pc, 32'h3040);

    // jr with misaligned target
    jr_tgt = 32'h3022; jr_req = 1;
    tick(); clr_pulses();
    chk("jr", pc, 32'h3020);
    chk_flags("jr", 0, 0, 1, 0);

    // Redirect during stall is parked
    stall = 1; j_req = 1;
    tick(); clr_pulses();
    chk("stall1_pc", pc, 32'h3020);
    chk("stall1_pend", {31'd0, pending}, 32'd1);
    tick();
    chk("stall2_pc", pc, 32'h3020);
    chk("stall2_pend", {31'd0, pending}, 32'd1);
    // Taken branch in the delay slot is illegal and dropped
    id_pc4 = 32'h3100; br_imm16 = 16'h0010; br_req = 1; br_taken = 1;
    tick(); clr_pulses();
    chk("stall3_pc", pc, 32'h3020);
    chk_flags("stall3", 1, 1, 1, 0);
    stall = 0;
    tick();
    chk("release_pc", pc, 32'h3040);
    chk("release_pend", {31'd0, pending}, 32'd0);
    tick();
    chk("after_release", pc, 32'h3044);

    // Out-of-range load still happens
    jr_tgt = 32'h0000_1000; jr_req = 1;
    tick(); clr_pulses();
    chk("range_pc", pc, 32'h1000);
    chk("range_flag", {31'd0, err_range}, 32'd1);

    // Reset overrides a pending redirect
    stall = 1; id_pc4 = 32'h3008; j_idx = 26'h0000C10; j_req = 1;
    tick(); clr_pulses();
    chk("pend_before_rst", {31'd0, pending}, 32'd1);
    reset = 0;
    tick();
    reset = 1; stall = 0;
    chk("rst2_pc", pc, 32'h3000);
    chk_flags("rst2", 0, 0, 0, 0);

    // Simultaneous j + jr: jr wins, conflict flagged
    jr_tgt = 32'h3100; j_idx = 26'h0000C10; j_req = 1; jr_req = 1;
    tick(); clr_pulses();
    chk("jjr_pc", pc, 32'h3100);
    chk_flags("jjr", 0, 1, 0, 0);

    // Wrap-around at top of address space
    jr_tgt = 32'hFFFF_FFFC; jr_req = 1;
    tick(); clr_pulses();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4, 32'h0);
    chk("wrap_range", {31'd0, err_range}, 32'd1);
    tick();
    chk("wrap_next", pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/npc_sequencer.md
Name: npc_sequencer

Overview:
- Owns the fetch PC register and decides the next PC every cycle.
- Candidate next PCs: sequential PC+4, conditional-branch target (PC4 + sign-extended 16-bit offset << 2), j/jal pseudo-direct target, and jr register target.
- Absorbs redirect pulses from the decode stage that arrive while fetch is stalled, so no redirect is lost.
- Sits between the decode-stage control/comparator and the instruction memory address port.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IMEM_LO, 32'h0000_3000, lowest legal instruction address (inclusive).
- IMEM_HI, 32'h0000_6FFC, highest legal instruction address (inclusive).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset: reset==0 at a rising edge resets the block.
- stall  in  1  hazard stall; PC holds while 1.
- id_pc4  in  32  PC+4 of the instruction currently in decode.
- br_req  in  1  single-cycle pulse: conditional branch resolved in decode.
- br_taken  in  1  branch condition result; qualified by br_req.
- br_imm16  in  16  raw branch offset field.
- j_req  in  1  single-cycle pulse: j/jal in decode.
- j_idx  in  26  instr_index field.
- jr_req  in  1  single-cycle pulse: jr/jalr in decode.
- jr_tgt  in  32  forwarded rs value.
- pc  out  32  current fetch address.
- pc4  out  32  pc+4, modulo 2^32.
- pending  out  1  a redirect is latched and waiting for stall release.
- err_conflict  out  1  sticky: illegal overlapping redirect.
- err_align  out  1  sticky: jr target not word-aligned.
- err_range  out  1  sticky: PC loaded outside [IMEM_LO, IMEM_HI].

Behaviour:
- Reset: pc=RESET_PC, state=IDLE, pending=0, all err_*=0, saved target=0. Reset takes priority over every other input in that cycle, including mid-pending.
- Redirect request (redir): jr_req | j_req | (br_req & br_taken). br_req with br_taken=0 is not a redirect.
- Target selection priority: jr > j > br.
  - jr: {jr_tgt[31:2],2'b00}.
  - j: {id_pc4[31:28], j_idx, 2'b00}.
  - br: id_pc4 + {{14{br_imm16[15]}}, br_imm16, 2'b00}.
  - All sums are modulo 2^32.
- More than one of jr_req / j_req / (br_req & br_taken) in the same cycle: err_conflict<=1; the priority winner is still used.
- jr accepted with jr_tgt[1:0]!=0: err_align<=1; low bits forced to 00.
- State IDLE:
  - stall=0, redir=0: pc<=pc+4.
  - stall=0, redir=1: pc<=target at the next edge (1-cycle latency).
  - stall=1, redir=0: pc holds.
  - stall=1, redir=1: saved<=target, go to PENDING, pc holds.
- State PENDING (pending=1):
  - stall=1: pc holds, saved holds.
  - stall=0: pc<=saved, go to IDLE.
  - Any redir while in PENDING (a branch in the delay slot is illegal): err_conflict<=1, the new request is dropped, saved is kept.
- err_range: set whenever the value being loaded into pc is <IMEM_LO or >IMEM_HI. The load still happens.
- Error flags: all sticky, cleared only by reset.
- Wrap-around: pc=32'hFFFF_FFFC with no redirect gives pc=0. Branch targets wrap likewise, and err_range flags the wrapped value if it is out of range.
- pc4 is combinational from pc; the other outputs are registered.

Decomposition:
- Shared package:
  - RESET_PC, IMEM_LO, IMEM_HI defaults.
  - 1-bit state encoding IDLE=0, PENDING=1.
  - 2-bit target-select constants SEL_SEQ/SEL_BR/SEL_J/SEL_JR.
- One combinational sub-module, npc_target_calc: id_pc4, br_imm16, j_idx, jr_tgt, selects -> 32-bit target. This reuses the branch-offset arithmetic.
- FSM, PC register and error flags stay in npc_sequencer.

Test Plan:
- Reset then 3 free cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; pending=0; all errors 0.
- br_req=1, br_taken=1, id_pc4=0x3004, br_imm16=0xFFFF, stall=0 -> next pc=0x3000. Repeat with imm 0x0004 -> pc=0x3014. With br_taken=0 -> pc=pc+4.
- j_req, id_pc4=0x3008, j_idx=26'h0000C10 -> pc=0x3040. jr_req, jr_tgt=0x3022 -> pc=0x3020, err_align=1.
- stall=1 with j pulse (target 0x3040) held for 3 cycles -> pc unchanged and pending=1 throughout. stall drops -> pc=0x3040 next edge, pending=0.
- In PENDING, br_req & br_taken pulse -> err_conflict=1, the saved target is still applied on release. Same-cycle j_req+jr_req -> jr target used, err_conflict=1.
- Redirect to 0x0000_1000 -> err_range=1, pc=0x1000. reset=0 while pending=1 -> pc=0x3000, pending=0, all errors cleared.
